// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction codes, IR capture pattern and next-state helper
package jtag_pkg;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;
  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_DBG     = 5'h10;
  localparam logic [4:0] IR_BYPASS  = 5'h1F;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:      return tms ? TLR    : RTI;
      RTI:      return tms ? SEL_DR : RTI;
      SEL_DR:   return tms ? SEL_IR : CAP_DR;
      CAP_DR:   return tms ? EX1_DR : SH_DR;
      SH_DR:    return tms ? EX1_DR : SH_DR;
      EX1_DR:   return tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: return tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   return tms ? UPD_DR : SH_DR;
      UPD_DR:   return tms ? SEL_DR : RTI;
      SEL_IR:   return tms ? TLR    : CAP_IR;
      CAP_IR:   return tms ? EX1_IR : SH_IR;
      SH_IR:    return tms ? EX1_IR : SH_IR;
      EX1_IR:   return tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: return tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   return tms ? UPD_IR : SH_IR;
      default:  return tms ? SEL_DR : RTI;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tck_sync.sv
// jtag_tck_sync: registers (or 2-flop syncs when JTAG_TAP_SYNC_EN) tck/tms/tdi/trstn and emits aligned tck_rise/tck_fall pulses
module jtag_tck_sync (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic trstn,
  output logic tms_s,
  output logic tdi_s,
  output logic trstn_s,
  output logic tck_rise,
  output logic tck_fall
);
  logic [3:0] pin, in_d, in_q, dly_q;
  logic rise_d, rise_q, fall_d, fall_q;
  assign pin = {trstn, tdi, tms, tck};
`ifdef JTAG_TAP_SYNC_EN
  logic [3:0] meta_q;
  always_ff @(posedge clk) meta_q <= rst ? 4'b1000 : pin;
  assign in_d = meta_q;
`else
  assign in_d = pin;
`endif
  always_comb begin
    rise_d = in_q[0] & ~dly_q[0];
    fall_d = ~in_q[0] & dly_q[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= 4'b1000;
      dly_q  <= 4'b1000;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      in_q   <= in_d;
      dly_q  <= in_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign {trstn_s, tdi_s, tms_s} = dly_q[3:1];
  assign tck_rise = rise_q;
  assign tck_fall = fall_q;
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: clk-domain JTAG TAP (FSM, IR, IDCODE/BYPASS/DBG DRs); JTAG_TAP_SYNC_EN selects 2-flop pin syncs
module jtag_tap_ctrl import jtag_pkg::*; #(
  parameter int          IR_WIDTH     = 5,
  parameter logic [31:0] IDCODE_VAL   = 32'h1DC0_0001,
  parameter int          DBG_DR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tck,
  input  logic                    tms,
  input  logic                    tdi,
  input  logic                    trstn,
  output logic                    tdo,
  output logic                    tdo_oe,
  output logic [IR_WIDTH-1:0]     ir_value,
  output logic                    dbg_capture,
  input  logic [DBG_DR_WIDTH-1:0] dbg_capture_data,
  output logic                    dbg_update,
  output logic [DBG_DR_WIDTH-1:0] dbg_update_data
);
  logic tms_s, tdi_s, trstn_s, tck_rise, tck_fall, tap_rst, sel_id, sel_dbg, shifting, sr_lsb;
  tap_state_e state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_value_q, ir_value_d;
  logic [31:0] id_sr_q, id_sr_d;
  logic [DBG_DR_WIDTH-1:0] dbg_sr_q, dbg_sr_d;
  logic byp_q, byp_d, tdo_q, tdo_d, tdo_oe_q, tdo_oe_d, cap_q, cap_d, dbg_update_q, dbg_update_d;
  jtag_tck_sync u_sync (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trstn(trstn),
    .tms_s(tms_s), .tdi_s(tdi_s), .trstn_s(trstn_s), .tck_rise(tck_rise), .tck_fall(tck_fall)
  );
  assign tap_rst  = rst || !trstn_s;
  assign sel_id   = ir_value_q == IR_WIDTH'(IR_IDCODE);
  assign sel_dbg  = ir_value_q == IR_WIDTH'(IR_DBG);
  assign shifting = state_q == SH_IR || state_q == SH_DR;
  always_comb begin
    state_d      = tck_rise ? tap_next(state_q, tms_s) : state_q;
    ir_sr_d      = ir_sr_q;
    ir_value_d   = ir_value_q;
    id_sr_d      = id_sr_q;
    dbg_sr_d     = dbg_sr_q;
    byp_d        = byp_q;
    cap_d        = tck_rise && state_d == CAP_DR;
    dbg_update_d = tck_rise && state_d == UPD_DR && sel_dbg;
    sr_lsb       = state_q == SH_IR ? ir_sr_q[0] : sel_id ? id_sr_q[0] : sel_dbg ? dbg_sr_q[0] : byp_q;
    tdo_d        = tck_fall && shifting ? sr_lsb : tdo_q;
    tdo_oe_d     = tck_fall ? shifting : tdo_oe_q;
    if (cap_q) begin
      id_sr_d  = IDCODE_VAL;
      dbg_sr_d = sel_dbg ? dbg_capture_data : dbg_sr_q;
      byp_d    = 1'b0;
    end
    if (tck_rise && state_q == SH_DR) begin
      id_sr_d  = sel_id ? {tdi_s, id_sr_q[31:1]} : id_sr_q;
      dbg_sr_d = sel_dbg ? {tdi_s, dbg_sr_q[DBG_DR_WIDTH-1:1]} : dbg_sr_q;
      byp_d    = sel_id || sel_dbg ? byp_q : tdi_s;
    end
    if (tck_rise && state_q == SH_IR) ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
    if (tck_rise && state_d == CAP_IR) ir_sr_d = IR_WIDTH'(IR_CAPTURE);
    if (tck_rise && state_d == UPD_IR) ir_value_d = ir_sr_q;
    if (tck_rise && state_d == TLR) ir_value_d = IR_WIDTH'(IR_IDCODE);
  end
  always_ff @(posedge clk) begin
    if (tap_rst) begin
      state_q      <= TLR;
      ir_sr_q      <= '0;
      ir_value_q   <= IR_WIDTH'(IR_IDCODE);
      id_sr_q      <= '0;
      dbg_sr_q     <= '0;
      byp_q        <= 1'b0;
      tdo_q        <= 1'b0;
      tdo_oe_q     <= 1'b0;
      cap_q        <= 1'b0;
      dbg_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_sr_q      <= ir_sr_d;
      ir_value_q   <= ir_value_d;
      id_sr_q      <= id_sr_d;
      dbg_sr_q     <= dbg_sr_d;
      byp_q        <= byp_d;
      tdo_q        <= tdo_d;
      tdo_oe_q     <= tdo_oe_d;
      cap_q        <= cap_d;
      dbg_update_q <= dbg_update_d;
    end
  end
  assign tdo             = tdo_q;
  assign tdo_oe          = tdo_oe_q;
  assign ir_value        = ir_value_q;
  assign dbg_capture     = cap_q && sel_dbg;
  assign dbg_update      = dbg_update_q;
  assign dbg_update_data = dbg_sr_q;
endmodule
